// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - shared state encoding and default width for tick_timer
package tick_timer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tick_down_counter.sv
// rtl/tick_down_counter.sv - loadable down-counter holding the remaining tick count
module tick_down_counter
   import tick_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             is_one
);

   // Load wins over dec; decrement wraps so a zero load means 2^WIDTH ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - WIDTH'(1);
      end
   end

   assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-counting timer with valid/ready expiry event and optional reload
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter bit RELOAD = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             TICK,
   input  logic             EN,
   input  logic             START,
   input  logic [WIDTH-1:0] PERIOD,
   input  logic             READY,
   output logic             VALID,
   output logic             OVERRUN,
   output logic             BUSY,
   output logic [WIDTH-1:0] O
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             cnt_load, cnt_dec;
   logic [WIDTH-1:0] cnt_value;
   logic [WIDTH-1:0] rem;
   logic             is_one;
   logic             qual_tick, expiry, accept;

   tick_down_counter #(.WIDTH(WIDTH)) u_counter (
      .clk        (CLK),
      .reset      (RESET),
      .load       (cnt_load),
      .load_value (cnt_value),
      .dec        (cnt_dec),
      .count      (rem),
      .is_one     (is_one)
   );

   assign qual_tick = (state_q == ST_RUN) && TICK && EN;
   assign expiry    = qual_tick && is_one;
   assign accept    = valid_q && READY;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         per_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_q     <= per_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      per_d     = per_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_value = per_q;

      if (START) begin
         state_d   = ST_RUN;
         per_d     = PERIOD;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
         cnt_load  = 1'b1;
         cnt_value = PERIOD;
      end else begin
         if (accept) begin
            valid_d = 1'b0;
         end
         // A new expiry re-asserts VALID; only an unaccepted pending event is lost.
         if (expiry) begin
            valid_d  = 1'b1;
            cnt_load = 1'b1;
            if (valid_q && !READY) begin
               overrun_d = 1'b1;
            end
            if (RELOAD) begin
               cnt_value = per_q;
            end else begin
               cnt_value = '0;
               state_d   = ST_DONE;
            end
         end else if (qual_tick) begin
            cnt_dec = 1'b1;
         end
         if ((state_q == ST_DONE) && accept) begin
            state_d = ST_IDLE;
         end
      end
   end

   assign VALID   = valid_q;
   assign OVERRUN = overrun_q;
   assign BUSY    = (state_q == ST_RUN);
   assign O       = rem;

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - self-checking bench for tick_timer in one-shot and reload builds
module tb_tick_timer;

   logic       CLK = 1'b0;
   logic       RESET, TICK, EN, START, READY;
   logic [7:0] PERIOD;
   logic       v0, ov0, b0, v1, ov1, b1;
   logic [7:0] o0, o1;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state per build (0 = one-shot, 1 = reload).
   // phase: 0 idle, 1 counting, 2 finished; left = ticks still needed to expiry.
   int m_phase[2];
   int m_left[2];
   int m_per[2];
   bit m_valid[2];
   bit m_ovr[2];

   always #5 CLK = ~CLK;

   tick_timer #(.WIDTH(8), .RELOAD(1'b0)) dut0 (
      .CLK(CLK), .RESET(RESET), .TICK(TICK), .EN(EN), .START(START),
      .PERIOD(PERIOD), .READY(READY), .VALID(v0), .OVERRUN(ov0), .BUSY(b0), .O(o0)
   );

   tick_timer #(.WIDTH(8), .RELOAD(1'b1)) dut1 (
      .CLK(CLK), .RESET(RESET), .TICK(TICK), .EN(EN), .START(START),
      .PERIOD(PERIOD), .READY(READY), .VALID(v1), .OVERRUN(ov1), .BUSY(b1), .O(o1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int ticks_for(input int p);
      return (p == 0) ? 256 : p;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit accept, expired, was_done;
         if (RESET) begin
            m_phase[k] = 0; m_left[k] = 0; m_per[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
         end else if (START) begin
            m_per[k]   = PERIOD;
            m_left[k]  = ticks_for(PERIOD);
            m_valid[k] = 0;
            m_ovr[k]   = 0;
            m_phase[k] = 1;
         end else begin
            accept   = m_valid[k] && READY;
            was_done = (m_phase[k] == 2);
            expired  = 0;
            if (m_phase[k] == 1 && TICK && EN) begin
               m_left[k] = m_left[k] - 1;
               expired   = (m_left[k] == 0);
            end
            if (expired) begin
               if (m_valid[k] && !READY) m_ovr[k] = 1;
               m_valid[k] = 1;
               if (k == 1) m_left[k] = ticks_for(m_per[k]);
               else        m_phase[k] = 2;
            end else if (accept) begin
               m_valid[k] = 0;
            end
            if (was_done && accept) m_phase[k] = 0;
         end
      end
   endtask

   function automatic int exp_o(input int k);
      return (m_phase[k] == 1) ? (m_left[k] % 256) : 0;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ":o0"},  {24'd0, o0}, exp_o(0));
      chk({tag, ":v0"},  {31'd0, v0}, {31'd0, m_valid[0]});
      chk({tag, ":ov0"}, {31'd0, ov0}, {31'd0, m_ovr[0]});
      chk({tag, ":b0"},  {31'd0, b0}, (m_phase[0] == 1) ? 1 : 0);
      chk({tag, ":o1"},  {24'd0, o1}, exp_o(1));
      chk({tag, ":v1"},  {31'd0, v1}, {31'd0, m_valid[1]});
      chk({tag, ":ov1"}, {31'd0, ov1}, {31'd0, m_ovr[1]});
      chk({tag, ":b1"},  {31'd0, b1}, (m_phase[1] == 1) ? 1 : 0);
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      check_model(tag);
   endtask

   initial begin
      RESET = 1; TICK = 0; EN = 0; START = 0; READY = 0; PERIOD = 8'd0;
      step("reset");
      step("reset");
      chk("reset_o", {24'd0, o0}, 0);
      chk("reset_busy", {31'd0, b0}, 0);
      chk("reset_valid", {31'd0, v1}, 0);

      // One-shot countdown, a tick every 16 cycles
      RESET = 0; EN = 1; PERIOD = 8'd3; START = 1;
      step("os_start");
      START = 0;
      for (int i = 0; i < 48; i++) begin
         TICK = ((i % 16) == 15);
         step("os_run");
      end
      TICK = 0;
      chk("os_valid", {31'd0, v0}, 1);
      chk("os_busy", {31'd0, b0}, 0);
      chk("os_o", {24'd0, o0}, 0);
      chk("os_reload_o", {24'd0, o1}, 3);
      READY = 1;
      step("os_accept");
      READY = 0;
      chk("os_valid_clr", {31'd0, v0}, 0);
      step("os_idle");

      // Reload with overrun
      PERIOD = 8'd2; START = 1;
      step("rl_start");
      START = 0; TICK = 1;
      step("rl_t1");
      step("rl_t2");
      chk("rl_valid_t2", {31'd0, v1}, 1);
      chk("rl_o_t2", {24'd0, o1}, 2);
      step("rl_t3");
      step("rl_t4");
      chk("rl_ovr_t4", {31'd0, ov1}, 1);
      chk("rl_o_t4", {24'd0, o1}, 2);
      chk("rl_oneshot_no_ovr", {31'd0, ov0}, 0);
      TICK = 0; READY = 1;
      step("rl_accept");
      READY = 0;

      // Back-to-back accept
      PERIOD = 8'd1; START = 1;
      step("bb_start");
      START = 0; TICK = 1; READY = 1;
      for (int i = 0; i < 10; i++) begin
         step("bb_run");
         chk("bb_valid", {31'd0, v1}, 1);
         chk("bb_ovr", {31'd0, ov1}, 0);
      end
      TICK = 0; READY = 0;

      // PERIOD = 0 means 256 ticks
      PERIOD = 8'd0; START = 1;
      step("p0_start");
      START = 0; TICK = 1;
      step("p0_t1");
      chk("p0_o_first", {24'd0, o0}, 255);
      for (int i = 0; i < 254; i++) step("p0_run");
      chk("p0_not_yet", {31'd0, v0}, 0);
      step("p0_t256");
      chk("p0_expire", {31'd0, v0}, 1);
      TICK = 0;

      // EN gating
      PERIOD = 8'd9; START = 1;
      step("en_start");
      START = 0; EN = 0; TICK = 1;
      for (int i = 0; i < 5; i++) step("en_gated");
      chk("en_hold", {24'd0, o0}, 9);
      EN = 1;

      // Build up an overrun, then START coincident with TICK and READY
      PERIOD = 8'd1; START = 1; TICK = 0;
      step("pr_setup");
      START = 0; TICK = 1; READY = 0;
      for (int i = 0; i < 3; i++) step("pr_ovr");
      chk("pr_ovr_set", {31'd0, ov1}, 1);
      PERIOD = 8'd7; START = 1; READY = 1;
      step("pr_start");
      START = 0; TICK = 0; READY = 0;
      chk("pr_o", {24'd0, o1}, 7);
      chk("pr_valid", {31'd0, v1}, 0);
      chk("pr_ovr_clr", {31'd0, ov1}, 0);

      // Reset mid-operation while VALID=1 and O=5
      PERIOD = 8'd5; START = 1;
      step("rs_start");
      START = 0; TICK = 1;
      for (int i = 0; i < 5; i++) step("rs_run");
      chk("rs_pre_valid", {31'd0, v1}, 1);
      chk("rs_pre_o", {24'd0, o1}, 5);
      RESET = 1; TICK = 0;
      step("rs_reset");
      chk("rs_o", {24'd0, o1}, 0);
      chk("rs_busy", {31'd0, b1}, 0);
      RESET = 0; TICK = 1;
      for (int i = 0; i < 5; i++) step("rs_ignored");
      chk("rs_still_idle", {24'd0, o1}, 0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 800; i++) begin
         RESET  = ($urandom % 80) == 0;
         START  = ($urandom % 24) == 0;
         PERIOD = (($urandom % 16) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
         TICK   = $urandom % 2;
         EN     = ($urandom % 4) != 0;
         READY  = ($urandom % 3) == 0;
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Purpose: downstream consumer of the 4-bit free-running counter carry-out. Counts wrap events (TICK), signals expiry with a valid/ready handshake, and optionally reloads.

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 8, bit width of period and remaining count.
- RELOAD, 0, 1 = auto-reload on expiry, 0 = one-shot.
REQ-002 Clocking: one clock, CLK; reset is RESET, synchronous, active-high.
REQ-003 Ports (name, direction, width, meaning):
- CLK, input, 1, rising-edge clock.
- RESET, input, 1, synchronous active-high reset.
- TICK, input, 1, count event; driven by the upstream counter's COUT.
- EN, input, 1, tick qualifier; TICK is ignored while EN=0.
- START, input, 1, single-cycle (re)start command.
- PERIOD, input, WIDTH, ticks per expiry; sampled only on START.
- READY, input, 1, consumer accepts the expiry event.
- VALID, output, 1, expiry event pending.
- OVERRUN, output, 1, sticky flag: an expiry was lost.
- BUSY, output, 1, high while in RUN.
- O, output, WIDTH, remaining tick count.

Function
REQ-004 FSM states IDLE, RUN, DONE. All outputs are registered.
REQ-005 Priority per edge: RESET > START > tick/handshake.
REQ-006 START in any state takes effect on the next edge:
- REM <= PERIOD and PER_Q <= PERIOD;
- VALID <= 0 and OVERRUN <= 0;
- state <= RUN.
A READY on the same cycle has no effect.
REQ-007 A qualified tick is TICK & EN in RUN. TICK is ignored in IDLE and DONE.
REQ-008 In RUN, a qualified tick with REM != 1 decrements REM modulo 2^WIDTH.
- PERIOD = 0 therefore yields 2^WIDTH ticks per expiry.
REQ-009 In RUN, a qualified tick with REM == 1 is an expiry:
- VALID <= 1, so VALID is high from the cycle after the expiry tick.
- If RELOAD=1: REM <= PER_Q and state stays RUN.
- If RELOAD=0: REM <= 0 and state <= DONE.
REQ-010 Handshake:
- VALID stays high until sampled with READY=1; it then clears on the next edge.
- READY while VALID=0 has no effect.
REQ-011 An expiry while VALID=1 and READY=0: OVERRUN <= 1 and VALID stays 1.
REQ-012 An expiry while VALID=1 and READY=1: VALID stays 1 and OVERRUN is unchanged (back-to-back accept, no loss).
REQ-013 Leaving DONE: goes to IDLE on the edge at which VALID is accepted.
REQ-014 BUSY = (state == RUN). O = REM.
REQ-015 OVERRUN is cleared only by RESET or START.
REQ-016 PER_Q is fixed between STARTs; changes on PERIOD without START have no effect.

Reset
REQ-017 On RESET=1 at an edge: state = IDLE; REM, PER_Q, VALID, OVERRUN and BUSY all 0.
REQ-018 RESET mid-RUN or mid-handshake discards the pending event with no residue.
- The first edge after RESET deasserts behaves as IDLE.

Structure
REQ-019 Shared package contents:
- state enum (IDLE/RUN/DONE) as 2-bit encoding;
- default WIDTH constant.
REQ-020 One sub-module, tick_down_counter: WIDTH-bit loadable down-counter with load, dec and is_one outputs. The FSM and handshake live in tick_timer.

Verification
REQ-021 One-shot countdown:
- Stimulus: RELOAD=0, PERIOD=3, START, TICK every 16 cycles, READY=0.
- Response: VALID rises one cycle after the 3rd tick; BUSY falls with it; O=0.
- Then READY=1 for 1 cycle: VALID=0 and state IDLE the next cycle.
REQ-022 Reload and overrun:
- Stimulus: RELOAD=1, PERIOD=2, 4 ticks, READY held 0.
- Response: VALID=1 after tick 2; OVERRUN=1 after tick 4; O reloads to 2 after each expiry.
REQ-023 Back-to-back accept:
- Stimulus: RELOAD=1, PERIOD=1, TICK held high, READY held high.
- Response: VALID stays 1 every cycle; OVERRUN stays 0.
REQ-024 PERIOD = 0:
- Stimulus: WIDTH=8, PERIOD=0, START.
- Response: exactly 256 qualified ticks to expiry; O reads 255 after the first tick.
REQ-025 Gating and priority:
- EN=0 with ticks: O is unchanged.
- START coincident with TICK and READY: O=PERIOD, VALID=0, OVERRUN=0 next cycle.
REQ-026 Reset mid-operation:
- Stimulus: RESET asserted while VALID=1 and O=5.
- Response: next cycle all outputs 0 and BUSY=0; ticks are then ignored until START.
